speed_counter: RTL and testbench
================================

Name: speed_counter

Overview:
- Up/down speed register driven by the key-control FSM's ENABLE/UP_DOWN outputs; it is the consumer end of that interface.
- Adds auto-repeat: one step per press, then periodic steps while the key stays held.
- Saturates at MIN_SPEED/MAX_SPEED.
- Generates a rate pulse TICK whose frequency rises with SPEED, for the downstream display/motor logic.

Parameters:
- WIDTH, 4: width of SPEED.
- MIN_SPEED, 0: lowest speed value.
- MAX_SPEED, 15: highest speed value; must be > MIN_SPEED and < 2^WIDTH.
- INIT_SPEED, 0: SPEED value on reset; must lie within MIN..MAX.
- HOLD_CYCLES, 50000000: cycles ENABLE must stay high after the first step before auto-repeat begins.
- REPEAT_CYCLES, 10000000: cycles between auto-repeat steps.
- BASE_DIV, 1000000: prescaler period, in cycles, for the TICK generator.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- ENABLE  input  1  step request from the key FSM (1 = key held).
- UP_DOWN  input  1  direction: 0 = increment, 1 = decrement.
- SPEED  output  WIDTH  current speed, registered.
- AT_MAX  output  1  high when SPEED == MAX_SPEED (combinational from SPEED).
- AT_MIN  output  1  high when SPEED == MIN_SPEED (combinational from SPEED).
- STEP  output  1  one-cycle pulse, registered, coincident with each change of SPEED.
- TICK  output  1  one-cycle rate pulse, registered.

Behaviour:
- Reset: RST high forces the following immediately, without waiting for CLK, and holds them while RST is high:
  - SPEED = INIT_SPEED, STEP = 0, TICK = 0.
  - state = IDLE; hold/repeat counter, prescaler and tick counter all = 0.
- FSM states: IDLE, HOLD, REPEAT.
  - IDLE: ENABLE sampled 1 at edge k → step request at edge k; go to HOLD; counter cleared.
  - HOLD: ENABLE = 0 → IDLE. Otherwise the counter increments each cycle; on the edge HOLD_CYCLES after entry → step request, counter cleared, go to REPEAT.
  - REPEAT: ENABLE = 0 → IDLE. Otherwise a step request every REPEAT_CYCLES edges; counter cleared on each step.
  - ENABLE falling always returns to IDLE on the next edge with no step. Re-pressing restarts the full HOLD delay.
- Step request timing:
  - UP_DOWN is sampled on the same edge as the request.
  - A direction change mid-hold affects only later steps; it does not restart the timers.
  - Latency: the new SPEED is visible after the requesting edge (1 cycle). STEP is high for exactly that one cycle.
- Step arithmetic:
  - Up: SPEED < MAX_SPEED → SPEED + 1; SPEED == MAX_SPEED → unchanged, STEP stays 0.
  - Down: SPEED > MIN_SPEED → SPEED − 1; SPEED == MIN_SPEED → unchanged, STEP stays 0.
  - The FSM still advances normally when saturated.
- TICK generation:
  - The prescaler counts 0..BASE_DIV−1 and emits an internal base pulse on wrap.
  - The tick counter counts base pulses 0..(MAX_SPEED − SPEED); TICK fires when it wraps.
  - TICK period = BASE_DIV × (MAX_SPEED − SPEED + 1) cycles.
  - On any STEP, the prescaler and tick counter both clear, so the new rate starts cleanly.
- Reset mid-operation: RST in HOLD or REPEAT returns to IDLE. After RST falls, a still-high ENABLE counts as a new press on the first edge: one step, then HOLD.
- Simultaneous events: a step and a TICK wrap on the same edge → the STEP clear wins, and TICK is suppressed on that edge.

Optional Feature:
- Macro: SPEED_WRAP_EN.
- Defined: no saturation.
  - Up at MAX_SPEED → MIN_SPEED, STEP = 1.
  - Down at MIN_SPEED → MAX_SPEED, STEP = 1.
  - AT_MAX/AT_MIN are unchanged in meaning.
- Undefined: saturating behaviour as described above.

Test Plan:
All scenarios use HOLD_CYCLES=4, REPEAT_CYCLES=2, BASE_DIV=2, MIN=0, MAX=15, INIT=0.
1. Reset and single press:
   - RST pulse → SPEED=0, AT_MIN=1, AT_MAX=0, STEP=0, TICK=0.
   - Then ENABLE=1, UP_DOWN=0 for 3 cycles → SPEED=1 after the first edge, exactly one STEP pulse, SPEED still 1 after release.
2. Auto-repeat:
   - ENABLE=1, UP from 0, held for edges 0..9 → steps at edges 0, 4, 6, 8.
   - Final SPEED=4, four STEP pulses; after release, state IDLE and no further steps.
3. Saturation:
   - Preload SPEED=15 via presses; press up → SPEED stays 15, AT_MAX=1, STEP=0.
   - With SPEED_WRAP_EN → SPEED=0, STEP=1.
   - At SPEED=0, press down → stays 0 (with SPEED_WRAP_EN → 15).
4. Direction change mid-hold:
   - From 5: press up (→6), flip UP_DOWN=1 at edge 2, keep holding → step at edge 4 gives 5, edge 6 gives 4.
5. TICK rate:
   - SPEED=15 → TICK every 2 cycles.
   - SPEED=14 → every 4 cycles.
   - SPEED=0 → every 32 cycles.
   - First TICK after a STEP arrives exactly one full period later.
6. Reset mid-REPEAT:
   - Assert RST at edge 7 of a hold → SPEED=0 immediately.
   - Release RST with ENABLE still 1 → one step to 1 on the next edge, then HOLD timing restarts.

Source files
------------

// File: rtl/speed_counter.sv
// Up/down speed register with press-and-hold auto-repeat and a speed-proportional TICK rate pulse.
// Define SPEED_WRAP_EN to wrap MAX<->MIN instead of saturating.
module speed_counter #(
   parameter int WIDTH         = 4,
   parameter int MIN_SPEED     = 0,
   parameter int MAX_SPEED     = 15,
   parameter int INIT_SPEED    = 0,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int BASE_DIV      = 1000000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENABLE,
   input  logic             UP_DOWN,
   output logic [WIDTH-1:0] SPEED,
   output logic             AT_MAX,
   output logic             AT_MIN,
   output logic             STEP,
   output logic             TICK
);

   localparam int CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int PW   = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_SPEED);
   localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_SPEED);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_SPEED);
   localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]    REP_LAST  = CW'(REPEAT_CYCLES - 1);
   localparam logic [PW-1:0]    PRE_LAST  = PW'(BASE_DIV - 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] speed_q, speed_d;
   logic             step_q, step_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] tcnt_q, tcnt_d;
   logic             tick_q, tick_d;
   logic             step_req;
   logic             base_pulse;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         speed_q <= INIT_V;
         step_q  <= 1'b0;
         pre_q   <= '0;
         tcnt_q  <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         speed_q <= speed_d;
         step_q  <= step_d;
         pre_q   <= pre_d;
         tcnt_q  <= tcnt_d;
         tick_q  <= tick_d;
      end
   end

   // Press/hold/repeat sequencing; releasing the key always drops back to IDLE without a step.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      step_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (ENABLE) begin
               step_req = 1'b1;
               state_d  = HOLD;
               cnt_d    = '0;
            end
         end
         HOLD: begin
            if (!ENABLE) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               step_req = 1'b1;
               state_d  = REPEAT;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         REPEAT: begin
            if (!ENABLE) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == REP_LAST) begin
               step_req = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      speed_d = speed_q;
      step_d  = 1'b0;
      if (step_req) begin
         if (!UP_DOWN) begin
            if (speed_q < MAX_V) begin
               speed_d = speed_q + 1'b1;
               step_d  = 1'b1;
            end
`ifdef SPEED_WRAP_EN
            else begin
               speed_d = MIN_V;
               step_d  = 1'b1;
            end
`endif
         end else begin
            if (speed_q > MIN_V) begin
               speed_d = speed_q - 1'b1;
               step_d  = 1'b1;
            end
`ifdef SPEED_WRAP_EN
            else begin
               speed_d = MAX_V;
               step_d  = 1'b1;
            end
`endif
         end
      end
   end

   // A real speed change restarts the rate generator, so a coincident wrap never produces TICK.
   assign base_pulse = (pre_q == PRE_LAST);

   always_comb begin
      pre_d  = pre_q;
      tcnt_d = tcnt_q;
      tick_d = 1'b0;
      if (step_d) begin
         pre_d  = '0;
         tcnt_d = '0;
      end else begin
         pre_d = base_pulse ? '0 : pre_q + 1'b1;
         if (base_pulse) begin
            if (tcnt_q == MAX_V - speed_q) begin
               tcnt_d = '0;
               tick_d = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
      end
   end

   assign SPEED  = speed_q;
   assign STEP   = step_q;
   assign TICK   = tick_q;
   assign AT_MAX = (speed_q == MAX_V);
   assign AT_MIN = (speed_q == MIN_V);

endmodule

// File: tb/tb_speed_counter.sv
// Directed and randomized checks of speed_counter against a timing-offset reference model.
module tb_speed_counter;
   localparam int W = 4, MINS = 0, MAXS = 15, INITS = 0, HOLDC = 4, REPC = 2, BDIV = 2;

   logic         CLK, RST, ENABLE, UP_DOWN;
   logic [W-1:0] SPEED;
   logic         AT_MAX, AT_MIN, STEP, TICK;

   int n_tests = 0;
   int n_fail  = 0;
   int step_seen = 0;

   // Reference state: speed, last outputs, key-held flag, edges since press, edges since rate restart.
   int m_speed, m_step, m_tick, m_age, m_since;
   bit m_held;

   speed_counter #(
      .WIDTH(W), .MIN_SPEED(MINS), .MAX_SPEED(MAXS), .INIT_SPEED(INITS),
      .HOLD_CYCLES(HOLDC), .REPEAT_CYCLES(REPC), .BASE_DIV(BDIV)
   ) dut (
      .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .UP_DOWN(UP_DOWN),
      .SPEED(SPEED), .AT_MAX(AT_MAX), .AT_MIN(AT_MIN), .STEP(STEP), .TICK(TICK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_speed = INITS; m_step = 0; m_tick = 0;
      m_held = 1'b0; m_age = 0; m_since = 0;
   endtask

   task automatic model_edge(input bit en, input bit ud);
      bit req;
      int nxt, period;
      req = 1'b0;
      if (!en) m_held = 1'b0;
      else if (!m_held) begin
         m_held = 1'b1; m_age = 0; req = 1'b1;
      end else begin
         m_age++;
         req = (m_age >= HOLDC) && (((m_age - HOLDC) % REPC) == 0);
      end
      m_step = 0;
      if (req) begin
         nxt = ud ? m_speed - 1 : m_speed + 1;
`ifdef SPEED_WRAP_EN
         if (nxt > MAXS) nxt = MINS;
         if (nxt < MINS) nxt = MAXS;
`else
         if (nxt > MAXS) nxt = MAXS;
         if (nxt < MINS) nxt = MINS;
`endif
         m_step  = (nxt != m_speed) ? 1 : 0;
         m_speed = nxt;
      end
      period = BDIV * (MAXS - m_speed + 1);
      if (m_step != 0) begin
         m_since = 0; m_tick = 0;
      end else begin
         m_since++;
         m_tick = ((m_since % period) == 0) ? 1 : 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".speed"},  SPEED,  m_speed);
      chk({tag, ".step"},   STEP,   m_step);
      chk({tag, ".tick"},   TICK,   m_tick);
      chk({tag, ".at_max"}, AT_MAX, (m_speed == MAXS) ? 1 : 0);
      chk({tag, ".at_min"}, AT_MIN, (m_speed == MINS) ? 1 : 0);
   endtask

   task automatic cycle(input bit en, input bit ud);
      ENABLE = en; UP_DOWN = ud;
      @(posedge CLK);
      model_edge(en, ud);
      #1;
      check_all("cyc");
      if (STEP === 1'b1) step_seen++;
   endtask

   task automatic press(input bit ud);
      cycle(1'b1, ud);
      cycle(1'b0, ud);
   endtask

   // Asynchronous reset mid-cycle, held across n edges; ENABLE is left as the caller set it.
   task automatic do_reset(input int n);
      #2 RST = 1'b1;
      #1;
      model_reset();
      check_all("rst");
      repeat (n) begin
         @(posedge CLK); #1;
         check_all("rst_hold");
      end
      RST = 1'b0;
   endtask

   task automatic wait_tick(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 200; i++) begin
         cycle(1'b0, 1'b0);
         if (TICK === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   int gap;

   initial begin
      RST = 1'b1; ENABLE = 1'b0; UP_DOWN = 1'b0;
      model_reset();
      do_reset(2);
      chk("reset_speed", SPEED, 0);
      chk("reset_at_min", AT_MIN, 1);
      chk("reset_at_max", AT_MAX, 0);

      // single press
      step_seen = 0;
      repeat (3) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      chk("press_speed", SPEED, 1);
      chk("press_steps", step_seen, 1);

      // auto-repeat: steps at edges 0,4,6,8
      do_reset(1);
      step_seen = 0;
      repeat (10) cycle(1'b1, 1'b0);
      repeat (4) cycle(1'b0, 1'b0);
      chk("repeat_speed", SPEED, 4);
      chk("repeat_steps", step_seen, 4);

      // saturation / wrap
      do_reset(1);
      repeat (15) press(1'b0);
      chk("preload_max", SPEED, 15);
      chk("preload_at_max", AT_MAX, 1);
      cycle(1'b1, 1'b0);
`ifdef SPEED_WRAP_EN
      chk("up_at_max", SPEED, 0);
      chk("up_at_max_step", STEP, 1);
`else
      chk("up_at_max", SPEED, 15);
      chk("up_at_max_step", STEP, 0);
`endif
      cycle(1'b0, 1'b0);
`ifndef SPEED_WRAP_EN
      do_reset(1);
`endif
      cycle(1'b1, 1'b1);
`ifdef SPEED_WRAP_EN
      chk("down_at_min", SPEED, 15);
`else
      chk("down_at_min", SPEED, 0);
`endif
      cycle(1'b0, 1'b1);

      // direction flip mid-hold
      do_reset(1);
      repeat (5) press(1'b0);
      for (int k = 0; k < 8; k++) begin
         cycle(1'b1, (k >= 2));
         if (k == 0) chk("flip_e0", SPEED, 6);
         if (k == 4) chk("flip_e4", SPEED, 5);
         if (k == 6) chk("flip_e6", SPEED, 4);
      end
      cycle(1'b0, 1'b0);

      // TICK periods
      do_reset(1);
      wait_tick(gap); wait_tick(gap);
      chk("tick_gap_0", gap, 32);
      repeat (15) press(1'b0);
      wait_tick(gap); wait_tick(gap);
      chk("tick_gap_15", gap, 2);
      cycle(1'b1, 1'b1);
      chk("to14_step", STEP, 1);
      wait_tick(gap);
      chk("first_tick_after_step", gap, 4);
      wait_tick(gap);
      chk("tick_gap_14", gap, 4);

      // reset mid-REPEAT with key still held
      do_reset(1);
      repeat (8) cycle(1'b1, 1'b0);
      chk("pre_rst_speed", SPEED, 3);
      do_reset(2);
      chk("rst_mid_speed", SPEED, 0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b0);
         if (k == 0) chk("rst_repress", SPEED, 1);
         if (k == 3) chk("rst_hold_e3", SPEED, 1);
         if (k == 4) chk("rst_hold_e4", SPEED, 2);
      end
      cycle(1'b0, 1'b0);

      // randomized hold/release episodes
      for (int ep = 0; ep < 300; ep++) begin
         int hl;
         bit ud;
         hl = int'($urandom_range(0, 24));
         ud = 1'($urandom % 2);
         for (int c = 0; c < hl; c++) begin
            if ($urandom_range(0, 15) == 0) ud = ~ud;
            cycle(1'b1, ud);
         end
         repeat (int'($urandom_range(0, 3))) cycle(1'b0, ud);
         if ($urandom_range(0, 39) == 0) begin
            ENABLE = 1'($urandom % 2);
            do_reset(1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
